// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback, runs the ready handshake
// with the unified memory, and traps on illegal opcodes or stalled requests.
// Optional build macro PERF_CNT_EN adds cycle and retired-instruction counters.
module multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [5:0]  i_opcode,
    input  logic [5:0]  i_funct,
    input  logic        i_zero_flag,
    input  logic        i_mem_ready,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic        o_iord,
    output logic        o_ir_write,
    output logic        o_pc_write,
    output logic [1:0]  o_pc_src,
    output logic [3:0]  o_alu_op,
    output logic        o_alu_src_a,
    output logic [1:0]  o_alu_src_b,
    output logic        o_bne,
    output logic        o_reg_write,
    output logic [1:0]  o_reg_dst,
    output logic [1:0]  o_wb_src,
    output logic        o_trap,
    output logic [1:0]  o_trap_cause
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] o_cycle_count,
    output logic [31:0] o_instr_count
`endif
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_WB_ALU,
        S_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_MEM,
        S_BRANCH,
        S_JUMP,
        S_JR,
        S_TRAP
    } state_t;

    localparam logic [7:0] WAIT_LIMIT    = 8'(MEM_WAIT_MAX);
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_BUS     = 2'd2;

    state_t      r_state;
    state_t      w_nextState;
    state_t      w_decodeTarget;
    logic [7:0]  r_waitCount;
    logic [1:0]  r_trapCause;
    logic [1:0]  w_nextCause;
    logic [3:0]  w_aluOpR;
    logic [3:0]  w_aluOpI;
    logic        w_memWaiting;
    logic        w_waitExpired;

    // A request is stalling whenever a memory-facing state sees no ready.
    assign w_memWaiting  = ((r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                            (r_state == S_MEM_WR)) && !i_mem_ready;
    assign w_waitExpired = w_memWaiting && (r_waitCount == WAIT_LIMIT);

    // Instruction classification: where DECODE goes for each opcode/funct.
    always_comb begin
        w_decodeTarget = S_TRAP;
        case (i_opcode)
            6'h00: begin
                case (i_funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2A, 6'h2B: w_decodeTarget = S_EXEC_R;
                    6'h08:                      w_decodeTarget = S_JR;
                    default:                    w_decodeTarget = S_TRAP;
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0D, 6'h0F: w_decodeTarget = S_EXEC_I;
            6'h23, 6'h2B:                             w_decodeTarget = S_ADDR;
            6'h04, 6'h05:                             w_decodeTarget = S_BRANCH;
            6'h02, 6'h03:                             w_decodeTarget = S_JUMP;
            default:                                  w_decodeTarget = S_TRAP;
        endcase
    end

    // ALU operation for R-type instructions, selected by funct.
    always_comb begin
        w_aluOpR = 4'd6;
        case (i_funct)
            6'h00:        w_aluOpR = 4'd0;
            6'h02:        w_aluOpR = 4'd1;
            6'h03:        w_aluOpR = 4'd2;
            6'h04:        w_aluOpR = 4'd3;
            6'h06:        w_aluOpR = 4'd4;
            6'h07:        w_aluOpR = 4'd5;
            6'h20, 6'h21: w_aluOpR = 4'd6;
            6'h22, 6'h23: w_aluOpR = 4'd7;
            6'h24:        w_aluOpR = 4'd8;
            6'h25:        w_aluOpR = 4'd9;
            6'h26:        w_aluOpR = 4'd10;
            6'h27:        w_aluOpR = 4'd11;
            6'h2A:        w_aluOpR = 4'd12;
            6'h2B:        w_aluOpR = 4'd13;
            default:      w_aluOpR = 4'd6;
        endcase
    end

    // ALU operation for I-type ALU instructions, selected by opcode.
    always_comb begin
        w_aluOpI = 4'd6;
        case (i_opcode)
            6'h08, 6'h09: w_aluOpI = 4'd6;
            6'h0A:        w_aluOpI = 4'd12;
            6'h0B:        w_aluOpI = 4'd13;
            6'h0D:        w_aluOpI = 4'd15;
            6'h0F:        w_aluOpI = 4'd14;
            default:      w_aluOpI = 4'd6;
        endcase
    end

    // Next-state and Moore outputs; reset forces every output low.
    always_comb begin
        w_nextState  = r_state;
        w_nextCause  = 2'd0;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_iord       = 1'b0;
        o_ir_write   = 1'b0;
        o_pc_write   = 1'b0;
        o_pc_src     = 2'd0;
        o_alu_op     = 4'd0;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = 2'd0;
        o_bne        = 1'b0;
        o_reg_write  = 1'b0;
        o_reg_dst    = 2'd0;
        o_wb_src     = 2'd0;
        o_trap       = 1'b0;
        o_trap_cause = 2'd0;
        if (!i_reset) begin
            case (r_state)
                S_FETCH: begin
                    o_mem_req   = 1'b1;
                    o_alu_src_b = 2'd1;
                    o_alu_op    = 4'd6;
                    if (i_mem_ready) begin
                        o_ir_write  = 1'b1;
                        o_pc_write  = 1'b1;
                        w_nextState = S_DECODE;
                    end else if (w_waitExpired) begin
                        w_nextState = S_TRAP;
                        w_nextCause = CAUSE_BUS;
                    end
                end
                S_DECODE: begin
                    o_alu_src_b = 2'd3;
                    o_alu_op    = 4'd6;
                    w_nextState = w_decodeTarget;
                    w_nextCause = CAUSE_ILLEGAL;
                end
                S_EXEC_R: begin
                    o_alu_src_a = 1'b1;
                    o_alu_op    = w_aluOpR;
                    w_nextState = S_WB_ALU;
                end
                S_EXEC_I: begin
                    o_alu_src_a = 1'b1;
                    o_alu_src_b = 2'd2;
                    o_alu_op    = w_aluOpI;
                    w_nextState = S_WB_ALU;
                end
                S_WB_ALU: begin
                    o_reg_write = 1'b1;
                    o_reg_dst   = (i_opcode == 6'h00) ? 2'd1 : 2'd0;
                    w_nextState = S_FETCH;
                end
                S_ADDR: begin
                    o_alu_src_a = 1'b1;
                    o_alu_src_b = 2'd2;
                    o_alu_op    = 4'd6;
                    w_nextState = (i_opcode == 6'h2B) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD, S_MEM_WR: begin
                    o_mem_req = 1'b1;
                    o_mem_we  = (r_state == S_MEM_WR);
                    o_iord    = 1'b1;
                    if (i_mem_ready) begin
                        w_nextState = (r_state == S_MEM_WR) ? S_FETCH : S_WB_MEM;
                    end else if (w_waitExpired) begin
                        w_nextState = S_TRAP;
                        w_nextCause = CAUSE_BUS;
                    end
                end
                S_WB_MEM: begin
                    o_reg_write = 1'b1;
                    o_wb_src    = 2'd1;
                    w_nextState = S_FETCH;
                end
                S_BRANCH: begin
                    o_alu_src_a = 1'b1;
                    o_alu_op    = 4'd7;
                    o_bne       = (i_opcode == 6'h05);
                    o_pc_src    = 2'd1;
                    o_pc_write  = i_zero_flag;
                    w_nextState = S_FETCH;
                end
                S_JUMP: begin
                    o_pc_src   = 2'd2;
                    o_pc_write = 1'b1;
                    if (i_opcode == 6'h03) begin
                        o_reg_write = 1'b1;
                        o_reg_dst   = 2'd2;
                        o_wb_src    = 2'd2;
                    end
                    w_nextState = S_FETCH;
                end
                S_JR: begin
                    o_pc_src    = 2'd3;
                    o_pc_write  = 1'b1;
                    w_nextState = S_FETCH;
                end
                S_TRAP: begin
                    o_trap       = 1'b1;
                    o_trap_cause = r_trapCause;
                end
                default: w_nextState = S_FETCH;
            endcase
        end
    end

    // State, stall counter and trap cause registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= S_FETCH;
            r_waitCount <= 8'd0;
            r_trapCause <= 2'd0;
        end else begin
            r_state <= w_nextState;
            if (w_nextState != r_state) begin
                r_waitCount <= 8'd0;
            end else if (w_memWaiting) begin
                r_waitCount <= r_waitCount + 8'd1;
            end
            if ((w_nextState == S_TRAP) && (r_state != S_TRAP)) begin
                r_trapCause <= w_nextCause;
            end
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] r_cycleCount;
    logic [31:0] r_instrCount;

    // Cycle counter freezes once halted; instructions retire on return to FETCH.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cycleCount <= 32'd0;
            r_instrCount <= 32'd0;
        end else begin
            if (r_state != S_TRAP) begin
                r_cycleCount <= r_cycleCount + 32'd1;
            end
            if ((w_nextState == S_FETCH) && (r_state != S_FETCH)) begin
                r_instrCount <= r_instrCount + 32'd1;
            end
        end
    end

    assign o_cycle_count = r_cycleCount;
    assign o_instr_count = r_instrCount;
`endif

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the ALU's 4-bit OP, shamt and immediate select, and its bne flag.
- Also drives the register-file, PC and memory enables, and performs a ready handshake with the unified instruction/data memory.

Parameters:
MEM_WAIT_MAX, 15, max cycles a memory request may stay pending before a bus-error trap (range 1..255)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero_flag  in  1  ALU Zero_flag (already inverted by ALU when bne=1)
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request valid
mem_we  out  1  1=write (sw), 0=read
iord  out  1  memory address: 0=PC, 1=ALUOut
ir_write  out  1  load instruction register
pc_write  out  1  load PC
pc_src  out  2  0=ALU result, 1=ALUOut, 2=jump target, 3=regA (jr)
alu_op  out  4  ALU OP code
alu_src_a  out  1  0=PC, 1=regA
alu_src_b  out  2  0=regB, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
bne  out  1  ALU bne select
reg_write  out  1  register-file write enable
reg_dst  out  2  0=rt, 1=rd, 2=$31
wb_src  out  2  0=ALUOut, 1=MDR, 2=PC
trap  out  1  sticky; core halted
trap_cause  out  2  0=none, 1=illegal instruction, 2=bus error

Behaviour:
- Reset (synchronous): state=FETCH; wait counter=0; trap=0; trap_cause=0; every other output 0.
- Moore outputs decode from the registered state; only pc_write and ir_write in FETCH are also gated by mem_ready.
- ALU OP encoding:
  - 0 sll, 1 srl, 2 sra, 3 sllv, 4 srlv, 5 srav, 6 add, 7 sub
  - 8 and, 9 or, 10 xor, 11 nor, 12 slt, 13 sltu, 14 lui, 15 ori
- FETCH:
  - Outputs: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=6.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, go to DECODE. Otherwise stay.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=3, alu_op=6 (branch target into ALUOut).
  - Next state by opcode/funct:
    - R-type (opcode 0): funct 00/02/03/04/06/07 -> EXEC_R; funct 20/21/22/23/24/25/26/27/2A/2B -> EXEC_R; funct 08 -> JR.
    - I-type ALU: 08/09 addi/addiu, 0A/0B slti/sltiu, 0D ori, 0F lui -> EXEC_I.
    - Memory: 23 lw, 2B sw -> ADDR.
    - Branch: 04 beq, 05 bne -> BRANCH.
    - Jump: 02 j, 03 jal -> JUMP.
    - Anything else -> TRAP, cause=1.
- EXEC_R:
  - alu_src_a=1, alu_src_b=0.
  - alu_op mapped from funct: add/addu->6, sub/subu->7, and->8, or->9, xor->10, nor->11, slt->12, sltu->13, shifts->0..5.
  - Go to WB_ALU.
- EXEC_I:
  - alu_src_a=1, alu_src_b=2.
  - alu_op: addi/addiu->6, slti->12, sltiu->13, ori->15, lui->14.
  - Go to WB_ALU.
- WB_ALU: reg_write=1, wb_src=0, reg_dst=1 for R-type else 0. Go to FETCH.
- ADDR: alu_src_a=1, alu_src_b=2, alu_op=6. lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: mem_req=1, mem_we=0, iord=1. Hold until mem_ready, then WB_MEM.
- MEM_WR: mem_req=1, mem_we=1, iord=1. Hold until mem_ready, then FETCH.
- WB_MEM: reg_write=1, wb_src=1, reg_dst=0. Go to FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=0, alu_op=7, bne=(opcode==05).
  - pc_src=1; pc_write=zero_flag.
  - Go to FETCH.
- JUMP: pc_src=2, pc_write=1. For jal also reg_write=1, reg_dst=2, wb_src=2. Go to FETCH.
- JR: pc_src=3, pc_write=1. Go to FETCH.
- TRAP: all enables 0, trap=1. Only reset leaves TRAP.
- Wait counter:
  - Counts consecutive cycles with mem_req=1 and mem_ready=0; cleared on any state change.
  - When it reaches MEM_WAIT_MAX while still not ready: TRAP, cause=2.
  - mem_ready arriving on that same cycle wins; no trap.
- mem_req stays high and its address stable until mem_ready; no request is ever withdrawn.
- Reset asserted mid-instruction wins over every transition; no partial writes follow.

Optional Feature:
PERF_CNT_EN
- Defined: adds outputs cycle_count[31:0] and instr_count[31:0].
  - cycle_count increments every cycle unless trap=1.
  - instr_count increments on every transition into FETCH from a non-FETCH state.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- add (op 00, funct 20), mem_ready=1 on first FETCH cycle -> 4 cycles total: FETCH, DECODE, EXEC_R with alu_op=6, WB_ALU with reg_write=1 and reg_dst=1.
- lw (op 23), mem_ready delayed 3 cycles in MEM_RD -> mem_req held 4 cycles with iord=1; then WB_MEM with wb_src=1.
- bne (op 05): zero_flag=1 -> pc_write=1, bne=1, alu_op=7; repeat with zero_flag=0 -> pc_write=0.
- jal (op 03) -> pc_write=1, pc_src=2, reg_write=1, reg_dst=2, wb_src=2 in a single cycle.
- Opcode 3F -> trap=1, trap_cause=1, all enables 0 for 20 cycles; reset -> FETCH with trap=0.
- MEM_WAIT_MAX=15, mem_ready held 0 in FETCH -> trap_cause=2 on the 16th cycle; with mem_ready on the 16th cycle -> no trap, DECODE.
